phase_acc_mc: RTL and testbench

- Multi-channel phase accumulator for the synth voice path. Next generation of the single-channel counter, which added an increment to its count every clock.
- One W-bit adder is shared round-robin across NCH channels; each channel has its own increment, phase, pending-sync bit and square output.
- Feeds wavetable address generation and oscillator square outputs. Increments are loaded through a simple config write port.

---
 rtl/phase_acc_mc_if.sv | 28 ++
 rtl/phase_acc_mc.sv | 121 ++++++++++++
 tb/tb_phase_acc_mc.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/phase_acc_mc_if.sv
// Config, sync and update bus for the multi-channel phase accumulator.
// master drives config/sync and consumes updates; slave is the accumulator.
interface phase_acc_mc_if #(
   parameter int W   = 32,
   parameter int NCH = 4,
   parameter int CW  = $clog2(NCH)
);
   logic           en;
   logic           cfg_we;
   logic [CW:0]    cfg_addr;
   logic [W-1:0]   cfg_data;
   logic [NCH-1:0] sync_req;
   logic           out_valid;
   logic [CW-1:0]  out_ch;
   logic [W-1:0]   out_phase;
   logic           out_wrap;
   logic [NCH-1:0] sq_out;

   modport master (
      output en, cfg_we, cfg_addr, cfg_data, sync_req,
      input  out_valid, out_ch, out_phase, out_wrap, sq_out
   );

   modport slave (
      input  en, cfg_we, cfg_addr, cfg_data, sync_req,
      output out_valid, out_ch, out_phase, out_wrap, sq_out
   );
endinterface

// File: rtl/phase_acc_mc.sv
// Round-robin phase accumulator: one shared W-bit adder serves NCH channels.
// Define PHASE_ACC_MC_OFFSET_EN to add per-channel output phase offsets.
module phase_acc_mc #(
   parameter  int W   = 32,
   parameter  int NCH = 4,
   localparam int CW  = $clog2(NCH)
) (
   input logic      clk,
   input logic      clr_n,
   phase_acc_mc_if.slave bus
);
   logic [CW-1:0]  idx_q, idx_d;
   logic [W-1:0]   phase_q [NCH];
   logic [W-1:0]   phase_d [NCH];
   logic [W-1:0]   inc_q [NCH];
   logic [W-1:0]   inc_d [NCH];
   logic [NCH-1:0] pend_q, pend_d;
   logic           out_valid_q, out_valid_d;
   logic [CW-1:0]  out_ch_q, out_ch_d;
   logic [W-1:0]   out_phase_q, out_phase_d;
   logic           out_wrap_q, out_wrap_d;
   logic [NCH-1:0] sq_q, sq_d;
`ifdef PHASE_ACC_MC_OFFSET_EN
   logic [W-1:0]   off_q [NCH];
   logic [W-1:0]   off_d [NCH];
`endif

   logic           sync_eff;
   logic [W:0]     sum;
   logic [W-1:0]   nxt;
   logic           wrap;
   logic [CW-1:0]  wr_ch;

   assign wr_ch = bus.cfg_addr[CW-1:0];

   always_comb begin
      idx_d       = idx_q;
      out_valid_d = bus.en;
      out_ch_d    = out_ch_q;
      out_phase_d = out_phase_q;
      out_wrap_d  = out_wrap_q;
      sq_d        = sq_q;
      for (int k = 0; k < NCH; k++) begin
         phase_d[k] = phase_q[k];
         inc_d[k]   = inc_q[k];
`ifdef PHASE_ACC_MC_OFFSET_EN
         off_d[k]   = off_q[k];
`endif
      end

      // Requests for non-serviced channels latch until their turn.
      pend_d   = pend_q | bus.sync_req;
      sync_eff = pend_q[idx_q] | bus.sync_req[idx_q];
      sum      = {1'b0, phase_q[idx_q]} + {1'b0, inc_q[idx_q]};
      nxt      = sync_eff ? '0 : sum[W-1:0];
      wrap     = ~sync_eff & sum[W];

      if (bus.en) begin
         pend_d[idx_q]  = 1'b0;
         phase_d[idx_q] = nxt;
         idx_d          = idx_q + CW'(1);
         out_ch_d       = idx_q;
         out_wrap_d     = wrap;
         sq_d[idx_q]    = nxt[W-1];
`ifdef PHASE_ACC_MC_OFFSET_EN
         out_phase_d    = nxt + off_q[idx_q];
`else
         out_phase_d    = nxt;
`endif
      end

      if (bus.cfg_we && !bus.cfg_addr[CW]) begin
         inc_d[wr_ch] = bus.cfg_data;
      end
`ifdef PHASE_ACC_MC_OFFSET_EN
      if (bus.cfg_we && bus.cfg_addr[CW]) begin
         off_d[wr_ch] = bus.cfg_data;
      end
`endif
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         idx_q       <= '0;
         pend_q      <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_phase_q <= '0;
         out_wrap_q  <= 1'b0;
         sq_q        <= '0;
         for (int k = 0; k < NCH; k++) begin
            phase_q[k] <= '0;
            inc_q[k]   <= '0;
`ifdef PHASE_ACC_MC_OFFSET_EN
            off_q[k]   <= '0;
`endif
         end
      end else begin
         idx_q       <= idx_d;
         pend_q      <= pend_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         out_phase_q <= out_phase_d;
         out_wrap_q  <= out_wrap_d;
         sq_q        <= sq_d;
         for (int k = 0; k < NCH; k++) begin
            phase_q[k] <= phase_d[k];
            inc_q[k]   <= inc_d[k];
`ifdef PHASE_ACC_MC_OFFSET_EN
            off_q[k]   <= off_d[k];
`endif
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_phase = out_phase_q;
   assign bus.out_wrap  = out_wrap_q;
   assign bus.sq_out    = sq_q;
endmodule

// File: tb/tb_phase_acc_mc.sv
// Directed bench for phase_acc_mc (NCH=4, W=32), hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_phase_acc_mc;
   localparam int W   = 32;
   localparam int NCH = 4;

   logic clk;
   logic clr_n;
   int   n_cmp;
   int   n_bad;

   phase_acc_mc_if #(.W(W), .NCH(NCH)) bus ();

   phase_acc_mc #(.W(W), .NCH(NCH)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.cfg_we   = 1'b0;
      bus.cfg_addr = '0;
      bus.cfg_data = '0;
      bus.sync_req = '0;
   endtask

   task automatic cfg(input logic sel, input int ch, input logic [W-1:0] d);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = {sel, 2'(ch)};
      bus.cfg_data = d;
   endtask

   // One enabled clock; checks the update it produced.
   task automatic step(input string tag, input int ch,
                       input logic [W-1:0] ph, input logic wr,
                       input logic [3:0] sq);
      @(negedge clk);
      check({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, ".ch"},    64'(bus.out_ch),    64'(ch));
      check({tag, ".phase"}, 64'(bus.out_phase), 64'(ph));
      check({tag, ".wrap"},  64'(bus.out_wrap),  64'(wr));
      check({tag, ".sq"},    64'(bus.sq_out),    64'(sq));
      idle();
   endtask

   logic [W-1:0] off_exp;

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      clr_n  = 1'b0;
      bus.en = 1'b1;
      idle();

      // Reset held with random activity on the inputs
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.cfg_we   = 1'($urandom);
         bus.cfg_addr = 3'($urandom);
         bus.cfg_data = $urandom;
         bus.sync_req = 4'($urandom);
      end
      @(negedge clk);
      check("rst.valid", 64'(bus.out_valid), 64'd0);
      check("rst.ch",    64'(bus.out_ch),    64'd0);
      check("rst.phase", 64'(bus.out_phase), 64'd0);
      check("rst.wrap",  64'(bus.out_wrap),  64'd0);
      check("rst.sq",    64'(bus.sq_out),    64'd0);
      idle();
      clr_n = 1'b1;
      step("first", 0, 32'h0, 1'b0, 4'b0000);

      // Load increments while paused; scan sits at idx 1
      bus.en = 1'b0;
      cfg(1'b0, 1, 32'h0000_0100);
      @(negedge clk);
      check("cfg.valid", 64'(bus.out_valid), 64'd0);
      cfg(1'b0, 2, 32'h8000_0000);
      @(negedge clk);
      cfg(1'b0, 3, 32'h0000_0010);
      @(negedge clk);
      idle();
      bus.en = 1'b1;

      step("A", 1, 32'h0000_0100, 1'b0, 4'b0000);
      step("B", 2, 32'h8000_0000, 1'b0, 4'b0100);
      step("C", 3, 32'h0000_0010, 1'b0, 4'b0100);
      step("D", 0, 32'h0,         1'b0, 4'b0100);
      step("E", 1, 32'h0000_0200, 1'b0, 4'b0100);
      step("F", 2, 32'h0,         1'b1, 4'b0000);
      step("G", 3, 32'h0000_0020, 1'b0, 4'b0000);
      step("H", 0, 32'h0,         1'b0, 4'b0000);
      step("I", 1, 32'h0000_0300, 1'b0, 4'b0000);
      step("J", 2, 32'h8000_0000, 1'b0, 4'b0100);
      step("K", 3, 32'h0000_0030, 1'b0, 4'b0100);

      // Sync for ch3 raised while ch0 is being serviced
      bus.sync_req = 4'b1000;
      step("L", 0, 32'h0,         1'b0, 4'b0100);
      step("M", 1, 32'h0000_0400, 1'b0, 4'b0100);
      step("N", 2, 32'h0,         1'b1, 4'b0000);
      step("O", 3, 32'h0,         1'b0, 4'b0000);
      step("P", 0, 32'h0,         1'b0, 4'b0000);
      step("Q", 1, 32'h0000_0500, 1'b0, 4'b0000);
      step("R", 2, 32'h8000_0000, 1'b0, 4'b0100);
      step("S", 3, 32'h0000_0010, 1'b0, 4'b0100);

      // Increment write colliding with the ch0 service
      cfg(1'b0, 0, 32'd5);
      step("T", 0, 32'h0,         1'b0, 4'b0100);
      step("U", 1, 32'h0000_0600, 1'b0, 4'b0100);
      step("V", 2, 32'h0,         1'b1, 4'b0000);
      step("W", 3, 32'h0000_0020, 1'b0, 4'b0000);
      step("X", 0, 32'd5,         1'b0, 4'b0000);

      // Pause 7 cycles; a sync for ch1 must wait it out
      bus.en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         bus.sync_req = (i == 2) ? 4'b0010 : 4'b0000;
         @(negedge clk);
         check("pause.valid", 64'(bus.out_valid), 64'd0);
      end
      check("pause.phase", 64'(bus.out_phase), 64'd5);
      check("pause.ch",    64'(bus.out_ch),    64'd0);
      idle();
      bus.en = 1'b1;
      step("Y", 1, 32'h0,         1'b0, 4'b0000);

      // Offset for ch1 written ahead of its next service
      cfg(1'b1, 1, 32'h4000_0000);
      step("Z",  2, 32'h8000_0000, 1'b0, 4'b0100);
      step("AA", 3, 32'h0000_0030, 1'b0, 4'b0100);
      step("AB", 0, 32'd10,        1'b0, 4'b0100);
`ifdef PHASE_ACC_MC_OFFSET_EN
      off_exp = 32'h4000_0100;
`else
      off_exp = 32'h0000_0100;
`endif
      step("AC", 1, off_exp,       1'b0, 4'b0100);

      // Reset mid-scan, then restart from ch0 with cleared increments
      clr_n = 1'b0;
      #1;
      check("rst2.valid", 64'(bus.out_valid), 64'd0);
      check("rst2.phase", 64'(bus.out_phase), 64'd0);
      check("rst2.sq",    64'(bus.sq_out),    64'd0);
      @(negedge clk);
      clr_n = 1'b1;
      step("R0", 0, 32'h0, 1'b0, 4'b0000);
      step("R1", 1, 32'h0, 1'b0, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
